// File: rtl/beta_pkg.sv
// Shared types for the beta memory arbiter: FSM states, transaction owner
// and the request payload captured into the holding registers.
package beta_pkg;

  localparam int unsigned MemAddrW   = 32;
  localparam int unsigned MemDataW   = 32;
  localparam int unsigned MemBeW     = MemDataW / 8;
  localparam int unsigned StarveCntW = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_IF,
    OWNER_LSU
  } mem_owner_t;

  typedef struct packed {
    logic                we;
    logic [MemBeW-1:0]   be;
    logic [MemAddrW-1:0] addr;
    logic [MemDataW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/beta_mem_arb_prio.sv
// Winner selection between fetch and LSU with a fetch starvation counter.
// Ports:
//   arb_en_i    - arbiter is idle and may grant this cycle
//   if_req_i    - fetch request
//   ls_req_i    - LSU request
//   cnt_i       - current starvation count
//   sel_if_c_o  - fetch wins (combinational)
//   sel_ls_c_o  - LSU wins (combinational)
//   cnt_c_o     - next starvation count (combinational)
module beta_mem_arb_prio
  import beta_pkg::*;
#(
  parameter int unsigned StarveLimit = 4
) (
  input  logic                  arb_en_i,
  input  logic                  if_req_i,
  input  logic                  ls_req_i,
  input  logic [StarveCntW-1:0] cnt_i,
  output logic                  sel_if_c_o,
  output logic                  sel_ls_c_o,
  output logic [StarveCntW-1:0] cnt_c_o
);

  localparam logic [StarveCntW-1:0] Limit = StarveCntW'(StarveLimit);

  // LSU preferred until fetch has lost Limit times in a row
  always_comb begin
    sel_if_c_o = 1'b0;
    sel_ls_c_o = 1'b0;
    cnt_c_o    = cnt_i;
    if (!if_req_i) begin
      // no fetch waiting: nothing to count, in any state
      cnt_c_o    = '0;
      sel_ls_c_o = arb_en_i & ls_req_i;
    end else if (arb_en_i) begin
      if (ls_req_i && (cnt_i < Limit)) begin
        sel_ls_c_o = 1'b1;
        cnt_c_o    = cnt_i + StarveCntW'(1);
      end else begin
        sel_if_c_o = 1'b1;
        cnt_c_o    = '0;
      end
    end
  end

endmodule

// File: rtl/beta_mem_arbiter.sv
// Shares the single data-memory port between fetch and the LSU, one
// outstanding transaction at a time, and routes the response to its owner.
// Ports:
//   clk_i, rstn_i              - clock, async active-low reset
//   if_req/addr_i, if_gnt_o    - fetch read request and capture pulse
//   if_rvalid_o, if_rdata_o    - fetch response
//   ls_req/we/be/addr/wdata_i  - LSU request; ls_gnt_o capture pulse
//   ls_rvalid_o, ls_rdata_o    - LSU response (also for stores)
//   mem_req/we/be/addr/wdata_o - OBI-style memory request
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i - memory handshake and response
//   arb_err_o                  - sticky protocol-error flag
module beta_mem_arbiter
  import beta_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   if_req_i,
  input  logic [AddrWidth-1:0]   if_addr_i,
  output logic                   if_gnt_o,
  output logic                   if_rvalid_o,
  output logic [DataWidth-1:0]   if_rdata_o,
  input  logic                   ls_req_i,
  input  logic                   ls_we_i,
  input  logic [DataWidth/8-1:0] ls_be_i,
  input  logic [AddrWidth-1:0]   ls_addr_i,
  input  logic [DataWidth-1:0]   ls_wdata_i,
  output logic                   ls_gnt_o,
  output logic                   ls_rvalid_o,
  output logic [DataWidth-1:0]   ls_rdata_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  output logic                   arb_err_o
);

  localparam int unsigned BeWidth = DataWidth / 8;

  arb_state_t            state_q, state_d;
  mem_owner_t            owner_q, owner_d;
  mem_req_t              hold_q, hold_d;
  logic [StarveCntW-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  sel_if, sel_ls;

  beta_mem_arb_prio #(
    .StarveLimit (StarveLimit)
  ) u_prio (
    .arb_en_i   (state_q == ARB_IDLE),
    .if_req_i   (if_req_i),
    .ls_req_i   (ls_req_i),
    .cnt_i      (cnt_q),
    .sel_if_c_o (sel_if),
    .sel_ls_c_o (sel_ls),
    .cnt_c_o    (cnt_d)
  );

  // State, owner, holding and error registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_NONE;
      hold_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next state, capture and response routing
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    hold_d      = hold_q;
    err_d       = err_q;
    mem_req_o   = 1'b0;
    if_rvalid_o = 1'b0;
    ls_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    ls_rdata_o  = '0;
    // grants only exist in idle; masked so reset shows all-zero outputs
    if_gnt_o    = sel_if & rstn_i;
    ls_gnt_o    = sel_ls & rstn_i;

    unique case (state_q)
      ARB_IDLE: begin
        if (mem_rvalid_i || mem_gnt_i) err_d = 1'b1;
        if (sel_ls) begin
          hold_d.we    = ls_we_i;
          hold_d.be    = MemBeW'(ls_be_i);
          hold_d.addr  = MemAddrW'(ls_addr_i);
          hold_d.wdata = MemDataW'(ls_wdata_i);
          owner_d      = OWNER_LSU;
          state_d      = ARB_REQ;
        end else if (sel_if) begin
          hold_d.we    = 1'b0;
          hold_d.be    = '1;
          hold_d.addr  = MemAddrW'(if_addr_i);
          hold_d.wdata = '0;
          owner_d      = OWNER_IF;
          state_d      = ARB_REQ;
        end
      end
      ARB_REQ: begin
        mem_req_o = 1'b1;
        if (mem_rvalid_i) err_d = 1'b1;
        if (mem_gnt_i) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_gnt_i) err_d = 1'b1;
        if (mem_rvalid_i) begin
          if (owner_q == OWNER_LSU) begin
            ls_rvalid_o = 1'b1;
            ls_rdata_o  = mem_rdata_i;
          end else if (owner_q == OWNER_IF) begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
          end
          owner_d = OWNER_NONE;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        owner_d = OWNER_NONE;
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign mem_we_o    = hold_q.we;
  assign mem_be_o    = BeWidth'(hold_q.be);
  assign mem_addr_o  = AddrWidth'(hold_q.addr);
  assign mem_wdata_o = DataWidth'(hold_q.wdata);
  assign arb_err_o   = err_q;

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Self-checking bench for beta_mem_arbiter: a small memory responder, a
// scoreboard of expected memory requests/responses, and directed scenarios.
module tb_beta_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i = 1'b0, ls_we_i = 1'b0;
  logic [3:0]  ls_be_i = '0;
  logic [31:0] ls_addr_i = '0, ls_wdata_i = '0;
  logic        ls_gnt_o, ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        arb_err_o;

  beta_mem_arbiter #(.AddrWidth(32), .DataWidth(32), .StarveLimit(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .arb_err_o(arb_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] outs();
    return 192'({if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
                 mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, arb_err_o});
  endfunction

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  // memory responder: grants after stall_cycles, answers one cycle later
  int          stall_cycles = 0;
  bit          force_rv = 1'b0;
  bit          hold_rsp = 1'b0;
  bit          acc_q = 1'b0;
  logic [31:0] acc_addr = '0;

  always @(negedge clk_i) begin
    acc_q    = rstn_i && mem_req_o && mem_gnt_i;
    acc_addr = mem_addr_o;
  end

  always @(posedge clk_i) begin
    #1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (acc_q && !hold_rsp) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_data(acc_addr);
    end
    if (force_rv) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hBAD0BAD0;
    end
    mem_gnt_i = 1'b0;
    if (mem_req_o) begin
      if (stall_cycles > 0) stall_cycles--;
      else mem_gnt_i = 1'b1;
    end
  end

  // scoreboard
  typedef struct {
    bit          lsu;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t rsp_q[$];
  bit   gnt_log[$];
  int   if_gnt_cnt = 0;
  int   ls_rv_cnt  = 0;
  bit   mon_en     = 1'b0;

  function automatic txn_t mk(input bit lsu, input bit we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.lsu = lsu; t.we = we; t.be = be; t.addr = addr; t.wdata = wdata;
    t.rdata = mem_data(addr);
    return t;
  endfunction

  always @(negedge clk_i) begin
    if (mon_en && rstn_i) begin
      txn_t t;
      if (if_gnt_o || ls_gnt_o) chk("gnt_exclusive", 192'(if_gnt_o & ls_gnt_o), 192'(0));
      if (if_gnt_o) begin gnt_log.push_back(1'b0); if_gnt_cnt++; end
      if (ls_gnt_o) gnt_log.push_back(1'b1);
      if (mem_req_o && mem_gnt_i) begin
        if (exp_q.size() == 0) chk("mem_req_expected", 192'(exp_q.size()), 192'(1));
        else begin
          t = exp_q.pop_front();
          chk($sformatf("mem_req@%0h", t.addr), 192'({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}),
              192'({t.we, t.be, t.addr, t.wdata}));
          rsp_q.push_back(t);
        end
      end
      if (if_rvalid_o || ls_rvalid_o) begin
        if (ls_rvalid_o) ls_rv_cnt++;
        if (rsp_q.size() == 0) chk("rsp_expected", 192'(rsp_q.size()), 192'(1));
        else begin
          t = rsp_q.pop_front();
          chk($sformatf("rsp@%0h", t.addr), 192'({if_rvalid_o, ls_rvalid_o, if_rdata_o, ls_rdata_o}),
              192'({!t.lsu, t.lsu, t.lsu ? 32'h0 : t.rdata, t.lsu ? t.rdata : 32'h0}));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || rsp_q.size() != 0) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    chk({tag, "_drain"}, 192'(exp_q.size() + rsp_q.size()), 192'(0));
  endtask

  // both sides request continuously until n grants; pat bit i = 1 -> LSU
  task automatic contend(input string tag, input int n, input logic [15:0] pat);
    int g = 0;
    int cyc = 0;
    gnt_log.delete();
    for (int i = 0; i < n; i++) begin
      if (pat[i]) exp_q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h400, 32'hCAFE0000));
      else        exp_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h300, 32'h0));
    end
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h300;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_be_i = 4'hF;
    ls_addr_i = 32'h400; ls_wdata_i = 32'hCAFE0000;
    while (g < n && cyc < 400) begin
      @(negedge clk_i);
      cyc++;
      if (if_gnt_o || ls_gnt_o) g++;
    end
    tick();
    if_req_i = 1'b0;
    ls_req_i = 1'b0;
    drain(tag);
    chk({tag, "_grants"}, 192'(gnt_log.size()), 192'(n));
    for (int i = 0; i < n && i < gnt_log.size(); i++)
      chk($sformatf("%s_order[%0d]", tag, i), 192'(gnt_log[i]), 192'(pat[i]));
  endtask

  initial begin
    int base;
    // reset
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("outputs_in_reset", outs(), 192'(0));
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("outputs_after_reset", outs(), 192'(0));
    mon_en = 1'b1;

    // fetch read, cycle-accurate latency
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    exp_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h100, 32'h0));
    @(negedge clk_i);
    chk("fetch_gnt_c0", 192'({if_gnt_o, ls_gnt_o, mem_req_o}), 192'(3'b100));
    tick();
    if_req_i = 1'b0; if_addr_i = 32'h5555;
    @(negedge clk_i);
    chk("fetch_mem_c1", 192'({mem_req_o, mem_we_o, mem_be_o, mem_addr_o}), 192'({1'b1, 1'b0, 4'hF, 32'h100}));
    tick();
    @(negedge clk_i);
    chk("fetch_rvalid_c2", 192'({if_rvalid_o, if_rdata_o, ls_rvalid_o, ls_rdata_o}),
        192'({1'b1, 32'hDEADBEEF, 1'b0, 32'h0}));

    // store granted at cycle 3, memory stalls 5 cycles
    base = ls_rv_cnt;
    stall_cycles = 5;
    tick();
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'b0011;
    ls_addr_i = 32'h200; ls_wdata_i = 32'h1234;
    exp_q.push_back(mk(1'b1, 1'b1, 4'b0011, 32'h200, 32'h1234));
    @(negedge clk_i);
    chk("store_gnt_c3", 192'({ls_gnt_o, if_gnt_o, mem_req_o}), 192'(3'b100));
    tick();
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_be_i = 4'hF;
    ls_addr_i = 32'hFFFF; ls_wdata_i = 32'hFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk($sformatf("store_hold[%0d]", i),
          192'({mem_req_o, mem_gnt_i, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}),
          192'({1'b1, 1'b0, 1'b1, 4'b0011, 32'h200, 32'h1234}));
      if (i < 4) tick();
    end
    drain("store");
    repeat (3) @(negedge clk_i);
    chk("store_rvalid_pulses", 192'(ls_rv_cnt - base), 192'(1));

    // starvation: L,L,L,L,F,L,L,L,L,F
    contend("contend10", 10, 16'h01EF);

    // fetch request withdrawn while LSU is served clears the counter
    base = if_gnt_cnt;
    exp_q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h500, 32'h0));
    tick();
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_be_i = 4'hF; ls_addr_i = 32'h500; ls_wdata_i = 32'h0;
    if_req_i = 1'b1; if_addr_i = 32'h600;
    @(negedge clk_i);
    chk("withdraw_gnt", 192'({ls_gnt_o, if_gnt_o}), 192'(2'b10));
    tick();
    ls_req_i = 1'b0;
    tick();
    if_req_i = 1'b0;
    drain("withdraw");
    repeat (3) @(negedge clk_i);
    chk("withdraw_no_fetch_gnt", 192'(if_gnt_cnt - base), 192'(0));
    contend("contend5", 5, 16'h000F);

    // stray response in idle
    @(negedge clk_i);
    chk("err_clear_before_stray", 192'(arb_err_o), 192'(0));
    force_rv = 1'b1;
    @(negedge clk_i);
    chk("stray_not_forwarded", 192'({if_rvalid_o, ls_rvalid_o, mem_rvalid_i}), 192'(3'b001));
    force_rv = 1'b0;
    @(negedge clk_i);
    chk("err_set", 192'(arb_err_o), 192'(1));
    repeat (5) @(negedge clk_i);
    chk("err_sticky", 192'(arb_err_o), 192'(1));

    // reset while waiting for a response
    hold_rsp = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h700, 32'h0));
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h700;
    tick();
    if_req_i = 1'b0;
    tick();
    @(negedge clk_i);
    chk("in_wait", 192'({mem_req_o, if_rvalid_o, ls_rvalid_o, rsp_q.size() == 1}), 192'(4'b0001));
    #1;
    rstn_i = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("reset_in_wait", outs(), 192'(0));
    exp_q.delete();
    rsp_q.delete();
    hold_rsp = 1'b0;
    @(negedge clk_i);
    chk("held_in_reset", outs(), 192'(0));
    rstn_i = 1'b1;
    mon_en = 1'b1;
    force_rv = 1'b1;
    @(negedge clk_i);
    chk("late_rsp_not_forwarded", 192'({if_rvalid_o, ls_rvalid_o, mem_rvalid_i, arb_err_o}), 192'(4'b0010));
    force_rv = 1'b0;
    @(negedge clk_i);
    chk("late_rsp_err", 192'(arb_err_o), 192'(1));

    repeat (3) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation reached 200000 time units, expected end of test earlier");
    $fatal(1, "watchdog");
  end

endmodule
